// File: rtl/demux_dispatch.sv
// rtl/demux_dispatch.sv - credit-gated FIFO feeder issuing registered din/sel to a 1-to-4 demux
module demux_dispatch #(
  parameter int DEPTH       = 4,
  parameter int CREDIT_INIT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_din,
  input  logic [1:0]               in_sel,
  output logic                     out_valid,
  output logic                     out_din,
  output logic [1:0]               out_sel,
  input  logic [3:0]               credit_ret,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     credit_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL  = DEPTH[AW:0];
  localparam logic [AW:0]   C_ONE = 1;
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [2:0]    CINIT = CREDIT_INIT[2:0];

  // Each entry packs {sel, din}
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_credit [4];
  logic          r_credit_err;
  logic          r_out_valid;
  logic          r_out_din;
  logic [1:0]    r_out_sel;

  logic          w_push;
  logic          w_pop;
  logic [2:0]    w_head;
  logic [1:0]    w_head_sel;
  logic [3:0]    w_issue;
  logic [3:0]    w_ovf;

  // Handshake and issue decisions come only from registered state, so returns land next cycle
  always_comb begin
    w_head     = r_mem[r_rptr];
    w_head_sel = w_head[2:1];
    w_push     = in_valid && (r_count < FULL);
    w_pop      = (r_count != '0) && (r_credit[w_head_sel] != 3'd0);
    w_issue    = w_pop ? (4'd1 << w_head_sel) : 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_ovf[i] = credit_ret[i] && !w_issue[i] && (r_credit[i] == CINIT);
    end
  end

  // FIFO storage and pointers; a full FIFO refuses pushes even when popping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {in_sel, in_din};
        r_wptr        <= r_wptr + P_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + P_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-channel credits: +return -issue, saturating at the initial value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_credit[i] <= CINIT;
      r_credit_err <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (credit_ret[i] && !w_issue[i]) begin
          if (r_credit[i] != CINIT) r_credit[i] <= r_credit[i] + 3'd1;
        end else if (!credit_ret[i] && w_issue[i]) begin
          r_credit[i] <= r_credit[i] - 3'd1;
        end
      end
      r_credit_err <= r_credit_err | (|w_ovf);
    end
  end

  // Registered demux drive: din forced low when idle, sel holds its last issued value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_din   <= 1'b0;
      r_out_sel   <= 2'b00;
    end else begin
      r_out_valid <= w_pop;
      r_out_din   <= w_pop ? w_head[0] : 1'b0;
      if (w_pop) r_out_sel <= w_head_sel;
    end
  end

  assign in_ready   = (r_count < FULL);
  assign count      = r_count;
  assign credit_err = r_credit_err;
  assign out_valid  = r_out_valid;
  assign out_din    = r_out_din;
  assign out_sel    = r_out_sel;

endmodule

// File: tb/tb_demux_dispatch.sv
// tb/tb_demux_dispatch.sv - scoreboard bench for demux_dispatch
module tb_demux_dispatch;
  localparam int DEPTH = 4;
  localparam int CINIT = 2;

  typedef struct {
    logic [1:0] sel;
    logic       din;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_din = 1'b0;
  logic [1:0] in_sel = 2'b00;
  logic       out_valid;
  logic       out_din;
  logic [1:0] out_sel;
  logic [3:0] credit_ret = 4'b0000;
  logic [2:0] count;
  logic       credit_err;

  int total = 0;
  int bad = 0;

  item_t mq[$];
  item_t exp_q[$];
  int    mcred[4];
  bit    m_err;
  bit    m_ov;
  bit    m_odin;
  int    m_osel;

  always #5 clk = ~clk;

  demux_dispatch #(.DEPTH(DEPTH), .CREDIT_INIT(CINIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_din(in_din), .in_sel(in_sel),
    .out_valid(out_valid), .out_din(out_din), .out_sel(out_sel),
    .credit_ret(credit_ret), .count(count), .credit_err(credit_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending requests and integer credit counts
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) mcred[i] = CINIT;
      m_err = 0; m_ov = 0; m_odin = 0; m_osel = 0;
    end else begin
      bit    issue;
      bit    accept;
      item_t it;
      issue  = (mq.size() > 0) && (mcred[mq[0].sel] > 0);
      accept = in_valid && (mq.size() < DEPTH);
      if (issue) begin
        it = mq.pop_front();
        exp_q.push_back(it);
        mcred[it.sel]--;
        m_ov = 1; m_odin = it.din; m_osel = it.sel;
      end else begin
        m_ov = 0; m_odin = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (credit_ret[i]) begin
          if (mcred[i] == CINIT) m_err = 1;
          else mcred[i]++;
        end
      end
      if (accept) begin
        it.sel = in_sel;
        it.din = in_din;
        mq.push_back(it);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an item
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", int'(count), mq.size());
      chk("in_ready", int'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("out_din_idle_or_data", int'(out_din), int'(m_odin));
      chk("out_sel", int'(out_sel), m_osel);
      chk("credit_err", int'(credit_err), int'(m_err));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          chk("sb_sel", int'(out_sel), int'(e.sel));
          chk("sb_din", int'(out_din), int'(e.din));
        end
      end
    end
  end

  task automatic drive(input logic v, input logic d, input logic [1:0] s, input logic [3:0] r);
    @(negedge clk);
    in_valid = v; in_din = d; in_sel = s; credit_ret = r;
  endtask

  function automatic logic [3:0] auto_r();
    logic [3:0] r;
    r = 4'b0000;
    if (m_ov) r[m_osel] = 1'b1;
    return r;
  endfunction

  task automatic idle(input int n, input bit autoret);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 2'b00, autoret ? auto_r() : 4'b0000);
  endtask

  // Holds the request until accepted; late tries return credits on the target channel
  task automatic push(input logic d, input logic [1:0] s, input bit autoret);
    int tries;
    bit done;
    logic [3:0] r;
    tries = 0; done = 0;
    while (!done && tries < 60) begin
      r = 4'b0000;
      if (autoret) r = auto_r();
      else if (tries >= 4 && (tries % 2) == 0 && mcred[s] < CINIT) r[s] = 1'b1;
      drive(1'b1, d, s, r);
      done = in_ready;
      tries++;
    end
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic restore();
    logic [3:0] r;
    bit settled;
    for (int k = 0; k < 200; k++) begin
      settled = (mq.size() == 0);
      for (int i = 0; i < 4; i++) if (mcred[i] != CINIT) settled = 0;
      if (settled) break;
      for (int i = 0; i < 4; i++) r[i] = (mcred[i] < CINIT);
      drive(1'b0, 1'b0, 2'b00, r);
    end
    idle(3, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("model_empty", mq.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_din", int'(out_din), 0);
    chk("rst_out_sel", int'(out_sel), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_credit_err", int'(credit_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, two-edge latency
    push(1'b1, 2'd2, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    chk("latency_not_yet", int'(out_valid), 0);
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    chk("latency_valid", int'(out_valid), 1);
    chk("latency_sel", int'(out_sel), 2);
    chk("latency_din", int'(out_din), 1);
    idle(2, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 4'b0100);
    idle(2, 1'b0);

    // Back-to-back stream with consumers returning credits
    push(1'b1, 2'd0, 1'b1);
    push(1'b0, 2'd1, 1'b1);
    push(1'b1, 2'd2, 1'b1);
    push(1'b1, 2'd3, 1'b1);
    push(1'b0, 2'd0, 1'b1);
    idle(4, 1'b1);
    restore();

    // Stall on channel 1 until a credit comes back
    push(1'b1, 2'd1, 1'b0);
    push(1'b0, 2'd1, 1'b0);
    push(1'b1, 2'd1, 1'b0);
    idle(5, 1'b0);
    chk("stall_valid", int'(out_valid), 0);
    chk("stall_din", int'(out_din), 0);
    chk("stall_count", int'(count), 1);
    drive(1'b0, 1'b0, 2'b00, 4'b0010);
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    drive(1'b0, 1'b0, 2'b00, 4'b0000);
    chk("stall_release", int'(out_valid), 1);
    restore();

    // Fill channel 0 behind a blocked head
    for (int k = 0; k < 6; k++) push(k[0], 2'd0, 1'b0);
    idle(2, 1'b0);
    restore();

    // Spurious return sets the sticky error
    drive(1'b0, 1'b0, 2'b00, 4'b1000);
    idle(3, 1'b0);
    chk("err_sticky", int'(credit_err), 1);

    // Random traffic with credit returns only for consumed items
    for (int k = 0; k < 400; k++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mcred[i] < CINIT) && ($urandom_range(0, 2) == 0);
      drive($urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom), r);
    end
    restore();

    // Asynchronous reset in the middle of a stream
    for (int k = 0; k < 6; k++) drive(1'b1, 1'($urandom), 2'($urandom), 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_din", int'(out_din), 0);
    chk("arst_out_sel", int'(out_sel), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_credit_err", int'(credit_err), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mcred[i] < CINIT) && ($urandom_range(0, 1) == 0);
      drive($urandom_range(0, 1) != 0, 1'($urandom), 2'($urandom), r);
    end
    restore();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
